sram1rw_mask_init: RTL
======================

Name: sram1rw_mask_init

Overview:
- Parametrised single-port (1RW) synchronous SRAM behavioural model; successor to the fixed 512x32 macro models.
- Adds generic depth and width, per-lane write mask, an optional output pipeline register and a read-valid strobe.
- Adds a hardware clear sequencer that writes INIT_VAL to every word after reset, so simulation and the cache arrays start deterministic.
- Sits under the cache/scratchpad wrappers in place of fixed-size SRAM macros.

Parameters:
- DEPTH, 512, number of words; any value >= 2.
- WIDTH, 32, bits per word.
- MASK_GRAN, 8, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register and read latency 2.
- INIT_VAL, 0, WIDTH-bit value written to every word by the clear sequencer.

Ports:
- CE  in  1  clock, rising edge.
- RSTB  in  1  asynchronous reset, active-low.
- A  in  ADDR_W=max(1,$clog2(DEPTH))  word address.
- CSB  in  1  chip select, active-low.
- WEB  in  1  write enable, active-low.
- OEB  in  1  read enable, active-low.
- BWEB  in  WIDTH/MASK_GRAN  per-lane write enable, active-low; bit k covers I[k*MASK_GRAN +: MASK_GRAN].
- I  in  WIDTH  write data.
- O  out  WIDTH  read data.
- OVALID  out  1  high for one cycle when O carries newly read data.
- BUSY  out  1  high while reset is asserted or the clear sequence is running.

Behaviour:
- RSTB low, asynchronous:
  - O=0, OVALID=0, BUSY=1.
  - Clear counter=0; FSM=CLEAR; pipeline valid bits=0.
  - Memory contents are not touched while RSTB is low.
- FSM states CLEAR and READY.
- CLEAR:
  - Each CE edge writes INIT_VAL to mem[cnt] with all lanes enabled, then increments cnt.
  - When cnt==DEPTH-1 is written, go to READY on the same edge.
  - The clear takes exactly DEPTH cycles after RSTB deasserts.
  - BUSY drops on the edge that performs the last clear write.
  - User inputs are ignored in CLEAR: no read, no write, OVALID stays 0.
- Reset reasserted mid-clear: the sequence aborts immediately; after release it restarts from address 0.
- READY, per CE edge:
  - RE = ~CSB & ~OEB; WE = ~CSB & ~WEB.
  - CSB high means no access regardless of WEB/OEB/BWEB.
- Write: for each lane k with BWEB[k]==0, mem[A] lane k <= I lane k. Lanes with BWEB[k]==1 keep their old value. WE with BWEB all ones changes nothing.
- Read, OUT_REG=0:
  - O <= mem[A] on the same edge; OVALID=1 for the following cycle.
  - Latency is 1 edge.
- Read, OUT_REG=1:
  - Stage-1 register captures mem[A]; O and OVALID update one edge later.
  - Latency is 2 edges; back-to-back reads give one result per cycle.
- Simultaneous RE and WE to the same address: read-first, so O returns the pre-write contents; the write lands on that edge.
- No read on an edge: O holds its last value (including 0 from reset), and OVALID deasserts.
- Out-of-range A (A >= DEPTH when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns all-X in simulation and OVALID still pulses.
- Pulse rules:
  - OVALID is never high while BUSY=1.
  - OVALID is never high for two cycles from a single read.
- Clear counter width is ADDR_W+1 so DEPTH equal to a power of two does not wrap early.

Test Plan:
- Clear/reset (DEPTH=512, INIT_VAL=0): release RSTB -> BUSY high for exactly 512 CE edges; then reading addresses 0, 255 and 511 returns 0x00000000 with OVALID pulsing 1 cycle after each read.
- Mask write: write 0xAABBCCDD to A=5 with BWEB=0000, then 0x11223344 with BWEB=1010, then read A=5 -> O=0xAA22CC44.
- Read-first: A=9 holds 0x12345678; assert RE and WE together with I=0xDEADBEEF, BWEB=0 -> O=0x12345678; the next read of A=9 -> 0xDEADBEEF.
- OUT_REG=1 pipeline: back-to-back reads of A=1, 2, 3 holding 0x1, 0x2, 0x3 -> O=0x1, 0x2, 0x3 on edges 2, 3, 4; OVALID high for 3 consecutive cycles; O holds 0x3 afterwards with OVALID=0.
- Reset mid-clear: drop RSTB at clear cycle 100 for 2 cycles -> O=0 and OVALID=0 immediately; on release BUSY stays high for a full 512 cycles; user writes issued during BUSY are absent after the clear.
- Chip deselect: CSB=1 with WEB=0, OEB=0, A=7, I=0xFFFFFFFF -> mem[7] unchanged, OVALID=0, O holds its previous value.

Source files
------------

// File: rtl/sram1rw_mask_init_if.sv
// Purpose : access bus of the 1RW masked SRAM model (address, controls, data, status).
// Latency : n/a (wires only).
// Backpressure: none; the master must hold off accesses while BUSY is high.
//
// Ports (master view): A, CSB, WEB, OEB, BWEB, I driven by the master;
// O, OVALID, BUSY driven by the memory. Control strobes are active-low.
interface sram1rw_mask_init_if #(
    parameter int ADDR_W = 9,
    parameter int WIDTH  = 32,
    parameter int NLANES = 4
);
    logic [ADDR_W-1:0] A;
    logic              CSB;
    logic              WEB;
    logic              OEB;
    logic [NLANES-1:0] BWEB;
    logic [WIDTH-1:0]  I;
    logic [WIDTH-1:0]  O;
    logic              OVALID;
    logic              BUSY;

    modport master (
        output A, CSB, WEB, OEB, BWEB, I,
        input  O, OVALID, BUSY
    );

    modport slave (
        input  A, CSB, WEB, OEB, BWEB, I,
        output O, OVALID, BUSY
    );
endinterface

// File: rtl/sram1rw_mask_init.sv
// Purpose : parametrised 1RW SRAM model with lane write mask, optional output register and post-reset clear.
// Latency : read data on O with OVALID 1 edge after the access (OUT_REG=0) or 2 edges (OUT_REG=1).
// Backpressure: none; one access per cycle once BUSY is low, all user inputs are ignored while BUSY is high.
//
// Ports: CE clock (rising), RSTB async active-low reset, bus = slave side of
// sram1rw_mask_init_if (A, CSB, WEB, OEB, BWEB, I in; O, OVALID, BUSY out).
module sram1rw_mask_init #(
    parameter int               DEPTH     = 512,
    parameter int               WIDTH     = 32,
    parameter int               MASK_GRAN = 8,
    parameter int               OUT_REG   = 0,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  logic              CE,
    input  logic              RSTB,
    sram1rw_mask_init_if.slave bus
);
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int NLANES = WIDTH / MASK_GRAN;
    // One extra bit so a power-of-two DEPTH can be represented by the counter.
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] clr_cnt;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range;
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] rd_dat;
    logic [WIDTH-1:0] o_q;
    logic             ovalid_q;

    // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
    assign in_range = ({1'b0, bus.A} < CNT_W'(DEPTH));
    assign rd_en    = (state == ST_READY) && !bus.CSB && !bus.OEB;
    assign wr_en    = (state == ST_READY) && !bus.CSB && !bus.WEB && in_range;
    assign rd_dat   = in_range ? mem[bus.A] : {WIDTH{1'bx}};

    // State is forced to CLEAR asynchronously, so BUSY also covers the reset window.
    assign bus.BUSY   = (state == ST_CLEAR);
    assign bus.O      = o_q;
    assign bus.OVALID = ovalid_q;

    // Memory has no reset term: holding RSTB low freezes its contents, and the
    // clear sequence starts on the first edge after release.
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            mem[clr_cnt[ADDR_W-1:0]] <= INIT_VAL;
            clr_cnt                  <= clr_cnt + 1'b1;
            if (clr_cnt == CNT_W'(DEPTH - 1)) begin
                state <= ST_READY;
            end
        end else if (wr_en) begin
            // Read path samples mem before this update lands: read-first.
            for (int k = 0; k < NLANES; k++) begin
                if (!bus.BWEB[k]) begin
                    mem[bus.A][k*MASK_GRAN +: MASK_GRAN] <= bus.I[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_out_direct
            always_ff @(posedge CE or negedge RSTB) begin
                if (!RSTB) begin
                    o_q      <= '0;
                    ovalid_q <= 1'b0;
                end else begin
                    ovalid_q <= rd_en;
                    if (rd_en) begin
                        o_q <= rd_dat;
                    end
                end
            end
        end else begin : g_out_reg
            logic [WIDTH-1:0] s1_dat;
            logic             s1_vld;

            always_ff @(posedge CE or negedge RSTB) begin
                if (!RSTB) begin
                    s1_dat   <= '0;
                    s1_vld   <= 1'b0;
                    o_q      <= '0;
                    ovalid_q <= 1'b0;
                end else begin
                    s1_vld   <= rd_en;
                    ovalid_q <= s1_vld;
                    if (rd_en) begin
                        s1_dat <= rd_dat;
                    end
                    if (s1_vld) begin
                        o_q <= s1_dat;
                    end
                end
            end
        end
    endgenerate
endmodule
